// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the fetch/data RAM port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Which requester currently owns the RAM port.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Access widths in bytes for the two ports.
  localparam int unsigned IF_BYTES = 10;
  localparam int unsigned DM_BYTES = 8;

  // True when an access of 'width' bytes starting at 'addr' fits in the RAM.
  // Full 64-bit unsigned compare, so huge addresses never wrap into range.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input int unsigned mem_bytes,
                                         input int unsigned width);
    logic [63:0] limit;
    limit = 64'(mem_bytes) - 64'(width);
    return (addr <= limit);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio_sel.sv
// Combinational grant selection: data first, fetch on starvation, plus the
// next value of the consecutive-data-grant streak counter.
module arb_prio_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned STREAK_W        = 3
) (
  input  logic                if_req,
  input  logic                dm_req,
  input  logic                if_flush,
  input  logic                excl_if,
  input  logic                excl_dm,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_valid,
  output owner_e              grant_owner,
  output logic [STREAK_W-1:0] streak_next
);

  logic if_elig_s;
  logic dm_elig_s;
  logic starve_s;

  // Pick the winner and compute the streak update for that choice.
  always_comb begin
    if_elig_s   = if_req && !if_flush && !excl_if;
    dm_elig_s   = dm_req && !excl_dm;
    starve_s    = if_req && (streak == STREAK_W'(MAX_DATA_STREAK));
    grant_valid = 1'b0;
    grant_owner = OWN_DM;
    streak_next = streak;
    if (if_elig_s && (!dm_elig_s || starve_s)) begin
      grant_valid = 1'b1;
      grant_owner = OWN_IF;
      streak_next = {STREAK_W{1'b0}};
    end else if (dm_elig_s) begin
      grant_valid = 1'b1;
      grant_owner = OWN_DM;
      if (if_req) begin
        if (streak == STREAK_W'(MAX_DATA_STREAK)) begin
          streak_next = streak;
        end else begin
          streak_next = streak + STREAK_W'(1);
        end
      end else begin
        streak_next = {STREAK_W{1'b0}};
      end
    end else begin
      streak_next = streak;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte RAM between the fetch stage (10-byte reads) and the memory
// stage (8-byte reads/writes). IDLE -> ACCESS -> RESP, registered responses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES       = 1024,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_ack_o,
  output logic [79:0] if_instr_o,
  output logic        if_err_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [63:0] dm_addr_i,
  input  logic [63:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [63:0] dm_rdata_o,
  output logic        dm_err_o,
  output logic        ram_r_en_o,
  output logic        ram_w_en_o,
  output logic [63:0] ram_addr_o,
  output logic [63:0] ram_wdata_o,
  input  logic [63:0] ram_rdata_i,
  input  logic [79:0] ram_instr_i
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  arb_state_e          state_r;
  arb_state_e          state_next_s;
  owner_e              owner_r;
  owner_e              grant_owner_s;
  logic [63:0]         addr_r;
  logic [63:0]         wdata_r;
  logic                we_r;
  logic                oor_r;
  logic [STREAK_W-1:0] streak_r;
  logic [STREAK_W-1:0] streak_next_s;
  logic                grant_valid_s;
  logic                grant_s;
  logic                arb_en_s;
  logic                excl_if_s;
  logic                excl_dm_s;
  logic                access_s;
  logic                if_ack_r;
  logic                if_err_r;
  logic [79:0]         if_instr_r;
  logic                dm_ack_r;
  logic                dm_err_r;
  logic [63:0]         dm_rdata_r;

  // Arbitration happens only in IDLE and RESP; RESP excludes the port just served,
  // because its request is still high during its ack cycle.
  assign arb_en_s  = (state_r == ST_IDLE) || (state_r == ST_RESP);
  assign excl_if_s = (state_r == ST_RESP) && (owner_r == OWN_IF);
  assign excl_dm_s = (state_r == ST_RESP) && (owner_r == OWN_DM);
  assign grant_s   = arb_en_s && grant_valid_s;
  assign access_s  = (state_r == ST_ACCESS);

  arb_prio_sel #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK),
    .STREAK_W       (STREAK_W)
  ) u_prio_sel (
    .if_req     (if_req_i),
    .dm_req     (dm_req_i),
    .if_flush   (if_flush_i),
    .excl_if    (excl_if_s),
    .excl_dm    (excl_dm_s),
    .streak     (streak_r),
    .grant_valid(grant_valid_s),
    .grant_owner(grant_owner_s),
    .streak_next(streak_next_s)
  );

  // Next-state logic for the access sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_next_s = ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_next_s = ST_RESP;
      end
      ST_RESP: begin
        if (grant_s) begin
          state_next_s = ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register and starvation streak counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      streak_r <= {STREAK_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (grant_s) begin
        streak_r <= streak_next_s;
      end
    end
  end

  // Latch the winning request so the RAM sees stable controls in ACCESS.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_r <= OWN_IF;
      addr_r  <= 64'd0;
      wdata_r <= 64'd0;
      we_r    <= 1'b0;
      oor_r   <= 1'b0;
    end else if (grant_s) begin
      owner_r <= grant_owner_s;
      if (grant_owner_s == OWN_IF) begin
        addr_r  <= if_addr_i;
        wdata_r <= 64'd0;
        we_r    <= 1'b0;
        oor_r   <= !addr_in_range(if_addr_i, MEM_BYTES, IF_BYTES);
      end else begin
        addr_r  <= dm_addr_i;
        wdata_r <= dm_wdata_i;
        we_r    <= dm_we_i;
        oor_r   <= !addr_in_range(dm_addr_i, MEM_BYTES, DM_BYTES);
      end
    end
  end

  // Capture the RAM result at the end of ACCESS; acks become one-cycle pulses in RESP.
  // A fetch flushed during its ACCESS still reads, but is neither acked nor captured.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_ack_r   <= 1'b0;
      if_err_r   <= 1'b0;
      if_instr_r <= 80'd0;
      dm_ack_r   <= 1'b0;
      dm_err_r   <= 1'b0;
      dm_rdata_r <= 64'd0;
    end else if (access_s) begin
      if (owner_r == OWN_IF) begin
        dm_ack_r <= 1'b0;
        dm_err_r <= 1'b0;
        if (if_flush_i) begin
          if_ack_r <= 1'b0;
          if_err_r <= 1'b0;
        end else begin
          if_ack_r   <= 1'b1;
          if_err_r   <= oor_r;
          if_instr_r <= oor_r ? 80'd0 : ram_instr_i;
        end
      end else begin
        if_ack_r   <= 1'b0;
        if_err_r   <= 1'b0;
        dm_ack_r   <= 1'b1;
        dm_err_r   <= oor_r;
        dm_rdata_r <= (oor_r || we_r) ? 64'd0 : ram_rdata_i;
      end
    end else begin
      if_ack_r <= 1'b0;
      if_err_r <= 1'b0;
      dm_ack_r <= 1'b0;
      dm_err_r <= 1'b0;
    end
  end

  // RAM pins are live only in ACCESS; the write enable is also cut by reset.
  assign ram_r_en_o  = access_s && !oor_r && !we_r;
  assign ram_w_en_o  = access_s && !oor_r && we_r && !rst_i;
  assign ram_addr_o  = access_s ? addr_r : 64'd0;
  assign ram_wdata_o = (access_s && we_r) ? wdata_r : 64'd0;

  assign if_ack_o   = if_ack_r;
  assign if_err_o   = if_err_r;
  assign if_instr_o = if_instr_r;
  assign dm_ack_o   = dm_ack_r;
  assign dm_err_o   = dm_err_r;
  assign dm_rdata_o = dm_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a byte RAM model, a shadow memory for
// expected values, directed edge cases and randomized concurrent traffic.
module tb_mem_port_arbiter;

  localparam int MEM     = 1024;
  localparam int TIMEOUT = 60;
  localparam logic [63:0] IF_MAX = 64'd1014;
  localparam logic [63:0] DM_MAX = 64'd1016;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req, if_flush, dm_req, dm_we;
  logic [63:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack_o, if_err_o, dm_ack_o, dm_err_o;
  logic [79:0] if_instr_o;
  logic [63:0] dm_rdata_o;
  logic        ram_r_en_o, ram_w_en_o;
  logic [63:0] ram_addr_o, ram_wdata_o, ram_rdata, ram_instr_lo;
  logic [79:0] ram_instr;
  logic        load_ram;

  logic [7:0] ram     [0:MEM-1];
  logic [7:0] ref_mem [0:MEM-1];

  typedef struct packed { logic [79:0] instr; logic err; } if_exp_t;
  typedef struct packed { logic [63:0] rdata; logic err; } dm_exp_t;
  if_exp_t if_q[$];
  dm_exp_t dm_q[$];
  if_exp_t mon_if_e;
  dm_exp_t mon_dm_e;

  int checks   = 0;
  int failures = 0;
  int en_count = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_BYTES(1024), .MAX_DATA_STREAK(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_ack_o(if_ack_o), .if_instr_o(if_instr_o), .if_err_o(if_err_o),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o), .dm_err_o(dm_err_o),
    .ram_r_en_o(ram_r_en_o), .ram_w_en_o(ram_w_en_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata), .ram_instr_i(ram_instr)
  );

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      0: return 8'h30;
      1: return 8'hf4;
      2: return 8'h00;
      3: return 8'h02;
      default: begin
        if (i < 10) return 8'h00;
        return 8'((i * 37 + 11) ^ (i >> 3));
      end
    endcase
  endfunction

  // RAM model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < MEM; i++) ram[i] <= init_byte(i);
    end else if (ram_w_en_o && ram_addr_o <= DM_MAX) begin
      for (int i = 0; i < 8; i++) ram[int'(ram_addr_o) + i] <= ram_wdata_o[8*i +: 8];
    end
  end

  always_comb begin
    ram_rdata    = 64'd0;
    ram_instr_lo = 64'd0;
    ram_instr    = 80'd0;
    if (ram_addr_o <= DM_MAX) begin
      for (int i = 0; i < 8; i++) ram_rdata[8*i +: 8] = ram[int'(ram_addr_o) + i];
    end
    if (ram_addr_o <= IF_MAX) begin
      for (int i = 0; i < 10; i++) ram_instr[8*i +: 8] = ram[int'(ram_addr_o) + i];
    end
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] exp_instr(input logic [63:0] a);
    logic [79:0] r;
    r = 80'd0;
    if (a <= IF_MAX) for (int i = 0; i < 10; i++) r[8*i +: 8] = ref_mem[int'(a) + i];
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever an ack appears and checks RAM enable sanity.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (if_ack_o) begin
        if (if_q.size() == 0) begin
          check("if_unexpected_ack", 80'(if_ack_o), 80'd0);
        end else begin
          mon_if_e = if_q.pop_front();
          check("if_instr", if_instr_o, mon_if_e.instr);
          check("if_err", 80'(if_err_o), 80'(mon_if_e.err));
        end
      end
      if (dm_ack_o) begin
        if (dm_q.size() == 0) begin
          check("dm_unexpected_ack", 80'(dm_ack_o), 80'd0);
        end else begin
          mon_dm_e = dm_q.pop_front();
          check("dm_rdata", 80'(dm_rdata_o), 80'(mon_dm_e.rdata));
          check("dm_err", 80'(dm_err_o), 80'(mon_dm_e.err));
        end
      end
      if (ram_r_en_o || ram_w_en_o) begin
        en_count++;
        check("ram_en_addr_in_range", 80'(ram_addr_o > DM_MAX), 80'd0);
        check("ram_en_exclusive", 80'(ram_r_en_o && ram_w_en_o), 80'd0);
      end
    end
  end

  task automatic do_fetch(input logic [63:0] a, input int flush_after, output int lat);
    if_exp_t e;
    int  cyc;
    bit  done;
    e.instr = exp_instr(a);
    e.err   = (a > IF_MAX);
    if_q.push_back(e);
    if_addr = a;
    if_req  = 1'b1;
    cyc = 0; done = 1'b0; lat = -1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (if_ack_o) begin
        lat = cyc; done = 1'b1;
      end else if (flush_after > 0 && cyc == flush_after) begin
        if_req   = 1'b0;
        if_flush = 1'b1;
        if_q.delete(if_q.size() - 1);
        @(negedge clk);
        if_flush = 1'b0;
        done = 1'b1;
      end else if (cyc >= TIMEOUT) begin
        check("fetch_timeout", 80'(cyc), 80'd2);
        if_q.delete(if_q.size() - 1);
        done = 1'b1;
      end
    end
    if_req = 1'b0;
  endtask

  task automatic do_data(input bit we, input logic [63:0] a, input logic [63:0] wd, output int lat);
    dm_exp_t e;
    int cyc;
    e.err   = (a > DM_MAX);
    e.rdata = 64'd0;
    if (!e.err) begin
      for (int i = 0; i < 8; i++) begin
        if (we) ref_mem[int'(a) + i] = wd[8*i +: 8];
        else    e.rdata[8*i +: 8] = ref_mem[int'(a) + i];
      end
    end
    dm_q.push_back(e);
    dm_we = we; dm_addr = a; dm_wdata = wd; dm_req = 1'b1;
    cyc = 0; lat = -1;
    while (lat < 0 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      if (dm_ack_o) lat = cyc;
    end
    if (lat < 0) begin
      check("data_timeout", 80'(cyc), 80'd2);
      dm_q.delete(dm_q.size() - 1);
    end
    dm_req = 1'b0;
  endtask

  // Both ports request in the same cycle; returns the cycle of each ack.
  task automatic both_fresh(input logic [63:0] fa, input logic [63:0] da, output int fc, output int dc);
    if_exp_t fe;
    dm_exp_t de;
    fe.instr = exp_instr(fa); fe.err = 1'b0;
    de.err = 1'b0;
    for (int i = 0; i < 8; i++) de.rdata[8*i +: 8] = ref_mem[int'(da) + i];
    if_q.push_back(fe);
    dm_q.push_back(de);
    if_addr = fa; if_req = 1'b1; if_flush = 1'b0;
    dm_addr = da; dm_we = 1'b0; dm_req = 1'b1;
    fc = -1; dc = -1;
    for (int c = 1; c <= TIMEOUT && (fc < 0 || dc < 0); c++) begin
      @(negedge clk);
      if (if_ack_o && fc < 0) begin fc = c; if_req = 1'b0; end
      if (dm_ack_o && dc < 0) begin dc = c; dm_req = 1'b0; end
    end
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_if_ack"}, 80'(if_ack_o), 80'd0);
    check({tag, "_dm_ack"}, 80'(dm_ack_o), 80'd0);
    check({tag, "_if_err"}, 80'(if_err_o), 80'd0);
    check({tag, "_dm_err"}, 80'(dm_err_o), 80'd0);
    check({tag, "_if_instr"}, if_instr_o, 80'd0);
    check({tag, "_dm_rdata"}, 80'(dm_rdata_o), 80'd0);
    check({tag, "_ram_en"}, 80'({ram_r_en_o, ram_w_en_o}), 80'd0);
    check({tag, "_ram_addr"}, 80'(ram_addr_o), 80'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int lat, fc, dc, en0;
    logic [79:0] saved;
    rst_i = 1'b1; load_ram = 1'b1;
    if_req = 1'b0; if_flush = 1'b0; if_addr = 64'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 64'd0; dm_wdata = 64'd0;
    for (int i = 0; i < MEM; i++) ref_mem[i] = init_byte(i);
    repeat (3) @(negedge clk);
    load_ram = 1'b0;
    check_quiet("reset");
    rst_i = 1'b0;
    @(negedge clk);

    // Fetch at 0: two-cycle latency, known instruction bytes.
    do_fetch(64'd0, 0, lat);
    check("fetch0_latency", 80'(lat), 80'd2);
    check("fetch0_instr", if_instr_o, 80'h0000000000000200f430);
    @(negedge clk);

    // Flush during ACCESS: no ack, instruction window holds.
    saved = if_instr_o;
    do_fetch(64'h00A, 1, lat);
    fc = 0;
    repeat (4) begin @(negedge clk); if (if_ack_o) fc++; end
    check("flush_no_ack", 80'(fc), 80'd0);
    check("flush_instr_hold", if_instr_o, saved);
    do_fetch(64'h038, 0, lat);
    check("after_flush_latency", 80'(lat), 80'd2);
    @(negedge clk);

    // Write then read back.
    do_data(1'b1, 64'h1F8, 64'h1122334455667788, lat);
    check("write_latency", 80'(lat), 80'd2);
    @(negedge clk);
    do_data(1'b0, 64'h1F8, 64'd0, lat);
    check("readback_value", 80'(dm_rdata_o), 80'h1122334455667788);
    @(negedge clk);

    // Bounds: last legal addresses, first illegal ones, and a huge address.
    en0 = en_count;
    do_fetch(64'h3F6, 0, lat);
    check("fetch_1014_enables", 80'(en_count - en0), 80'd1);
    @(negedge clk);
    en0 = en_count;
    do_fetch(64'h3F7, 0, lat);
    check("fetch_1015_no_enable", 80'(en_count - en0), 80'd0);
    @(negedge clk);
    do_data(1'b0, 64'h3F8, 64'd0, lat);
    @(negedge clk);
    en0 = en_count;
    do_data(1'b1, 64'h3F9, 64'hDEADBEEFCAFEF00D, lat);
    check("write_oor_no_enable", 80'(en_count - en0), 80'd0);
    for (int i = 0; i < 7; i++) check("write_oor_ram_kept", 80'(ram[16'h3F9 + i]), 80'(ref_mem[16'h3F9 + i]));
    @(negedge clk);
    do_data(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, lat);
    repeat (2) @(negedge clk);

    // Priority: fresh simultaneous requests, data first when streak is low.
    both_fresh(64'h040, 64'h050, fc, dc);
    check("prio_a_dm_cycle", 80'(dc), 80'd2);
    check("prio_a_if_cycle", 80'(fc), 80'd4);
    repeat (2) @(negedge clk);
    // Four data grants while fetch waits (blocked by flush) saturate the streak.
    if_req = 1'b1; if_flush = 1'b1; if_addr = 64'h060;
    for (int k = 0; k < 4; k++) do_data(1'b0, 64'(112 + 8 * k), 64'd0, lat);
    @(negedge clk);
    both_fresh(64'h060, 64'h078, fc, dc);
    check("prio_b_if_cycle", 80'(fc), 80'd2);
    check("prio_b_dm_cycle", 80'(dc), 80'd4);
    repeat (2) @(negedge clk);
    both_fresh(64'h080, 64'h090, fc, dc);
    check("prio_c_dm_cycle", 80'(dc), 80'd2);
    check("prio_c_if_cycle", 80'(fc), 80'd4);
    repeat (2) @(negedge clk);

    // Reset during ACCESS of a write: RAM untouched, everything back to idle.
    dm_we = 1'b1; dm_addr = 64'h100; dm_wdata = 64'hA5A5A5A5A5A5A5A5; dm_req = 1'b1;
    @(negedge clk);
    rst_i = 1'b1; dm_req = 1'b0;
    #1;
    check("rst_access_w_en", 80'(ram_w_en_o), 80'd0);
    @(negedge clk);
    check_quiet("rst_access");
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) check("rst_access_ram_kept", 80'(ram[256 + i]), 80'(ref_mem[256 + i]));
    @(negedge clk);

    // Random concurrent traffic on both ports.
    fork
      begin
        int flat;
        logic [63:0] a;
        for (int n = 0; n < 60; n++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) a = 64'($urandom_range(1015, 1023));
            else a = {32'hFFFF_FFFF, $urandom};
          end else begin
            a = 64'($urandom_range(0, 502));
          end
          do_fetch(a, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, flat);
        end
      end
      begin
        int dlat;
        bit we;
        logic [63:0] a;
        for (int n = 0; n < 60; n++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          we = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) a = 64'($urandom_range(1017, 1023));
            else a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
          end else if (we) begin
            a = 64'($urandom_range(512, 1016));
          end else begin
            a = 64'($urandom_range(0, 1016));
          end
          do_data(we, a, {$urandom, $urandom}, dlat);
        end
      end
    join

    repeat (5) @(negedge clk);
    check("if_queue_drained", 80'(if_q.size()), 80'd0);
    check("dm_queue_drained", 80'(dm_q.size()), 80'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
